// File: rtl/ysyx_23060075_ifu_fetch_buf.sv
// ysyx_23060075_ifu_fetch_buf
//
// Instruction fetch unit with a decoupled valid/ready instruction-memory
// port and a small instruction queue toward decode. Owns the fetch PC, keeps
// at most one memory transaction outstanding, and queues returned
// instructions together with their PC and fault bit. Control-flow redirects
// from execute flush the queue and cause any in-flight response to be dropped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_en                 permits new fetch requests
//   redirect_valid/_pc       control-flow redirect and its target (low 2 bits ignored)
//   imem_req_valid/_ready    fetch request handshake
//   imem_req_addr            fetch address (stable while request pending)
//   imem_rsp_valid/_data/_err   fetch response, always accepted
//   inst_valid/_ready        queue head handshake toward decode
//   inst, inst_pc, inst_snpc, inst_fault   queue head contents
module ysyx_23060075_ifu_fetch_buf #(
    parameter int unsigned ISA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ISA_WIDTH-1:0]  redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ISA_WIDTH-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ISA_WIDTH-1:0]  inst_pc,
    output logic [ISA_WIDTH-1:0]  inst_snpc,
    output logic                  inst_fault
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [ISA_WIDTH-1:0] PC_STEP = ISA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t                 state, state_n;
    logic [ISA_WIDTH-1:0]   fetch_pc, fetch_pc_n;
    logic [ISA_WIDTH-1:0]   req_addr, req_addr_n;
    logic                   stale, stale_n;

    logic [INST_WIDTH-1:0]  q_data [QUEUE_DEPTH];
    logic [ISA_WIDTH-1:0]   q_pc   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_fault;
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count, count_after;

    logic                   push, pop;
    logic [ISA_WIDTH-1:0]   redirect_target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Masking keeps every redirect_pc bit in use while forcing word alignment.
    assign redirect_target = redirect_pc & ~ISA_WIDTH'(3);

    // A response arriving together with a redirect belongs to the old path.
    assign push        = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop         = inst_ready && (count != '0);
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            stale    <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_addr <= req_addr_n;
            stale    <= stale_n;
        end
    end

    always_comb begin
        state_n        = state;
        fetch_pc_n     = fetch_pc;
        req_addr_n     = req_addr;
        stale_n        = stale;
        imem_req_valid = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (fetch_en && !redirect_valid && (count < DEPTH_C)) begin
                    req_addr_n = fetch_pc;
                    state_n    = S_REQ;
                end
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    fetch_pc_n = req_addr + PC_STEP;
                    state_n    = (stale || redirect_valid) ? S_DROP : S_WAIT;
                    stale_n    = 1'b0;
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn; remember to drop its response.
                    stale_n = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_n = imem_rsp_valid ? S_IDLE : S_DROP;
                end else if (imem_rsp_valid) begin
                    if (fetch_en && (count_after < DEPTH_C)) begin
                        req_addr_n = fetch_pc;
                        state_n    = S_REQ;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_n = redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_fault <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_data[tail]  <= imem_rsp_data;
                q_pc[tail]    <= req_addr;
                q_fault[tail] <= imem_rsp_err;
                tail          <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count <= count_after;
        end
    end

    assign imem_req_addr = req_addr;
    assign inst_valid    = (count != '0);
    assign inst          = q_data[head];
    assign inst_pc       = q_pc[head];
    assign inst_snpc     = q_pc[head] + PC_STEP;
    assign inst_fault    = q_fault[head];

endmodule

// File: tb/tb_ysyx_23060075_ifu_fetch_buf.sv
// Randomized bench for ysyx_23060075_ifu_fetch_buf. A transaction-level
// reference model (expected next fetch address, a queue of expected
// instructions, and a taint flag per memory transaction) predicts the
// request stream and the decode-side head every cycle.
module tb_ysyx_23060075_ifu_fetch_buf;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int NCYC = 4000;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_snpc;
    logic        inst_fault;

    ysyx_23060075_ifu_fetch_buf #(
        .ISA_WIDTH(32),
        .INST_WIDTH(32),
        .RESET_PC(RST_PC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_snpc(inst_snpc),
        .inst_fault(inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    typedef enum {T_NONE, T_PRES, T_AWAIT} txn_t;

    ent_t        mq[$];
    txn_t        txn;
    logic [31:0] next_addr;
    logic [31:0] held_addr;
    logic        taint;
    logic        new_pres;
    logic        exp_req_valid;
    int          pops = 0;

    task automatic model_reset();
        mq.delete();
        txn           = T_NONE;
        next_addr     = RST_PC;
        held_addr     = RST_PC;
        taint         = 1'b0;
        new_pres      = 1'b0;
        exp_req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_snpc", inst_snpc, 4);
        check("rst_inst_fault", inst_fault, 0);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(4))
            0: return 32'h8000_0100;
            1: return 32'h8000_0103;
            2: return 32'h8000_0200;
            3: return 32'hFFFF_FFF0 | 32'($urandom_range(3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   en_pct;
        int   rdy_pct;
        int   cnt0;
        logic stray;
        logic nxt_valid;
        logic [31:0] snpc_exp;

        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            stray = 1'b0;
            if (cyc == NCYC / 2) begin
                // Mid-run reset, then a stray response that must be ignored.
                rst            = 1'b1;
                fetch_en       = 1'b0;
                redirect_valid = 1'b0;
                imem_rsp_valid = 1'b0;
                inst_ready     = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                check_reset_outputs();
                stray = 1'b1;
            end

            // Observe outputs against the model state after the last edge.
            check("req_valid", imem_req_valid, exp_req_valid);
            if (exp_req_valid && imem_req_valid) begin
                if (new_pres) check("req_addr_new", imem_req_addr, next_addr);
                else          check("req_addr_hold", imem_req_addr, held_addr);
            end
            check("inst_valid", inst_valid, mq.size() != 0);
            if (mq.size() != 0 && inst_valid) begin
                snpc_exp = mq[0].pc + 32'd4;
                check("inst", inst, mq[0].data);
                check("inst_pc", inst_pc, mq[0].pc);
                check("inst_snpc", inst_snpc, snpc_exp);
                check("inst_fault", inst_fault, mq[0].fault);
            end

            // Drive this cycle's inputs.
            en_pct  = (((cyc / 300) % 4) == 3) ? 20 : 90;
            case ((cyc / 250) % 3)
                0: rdy_pct = 0;
                1: rdy_pct = 50;
                default: rdy_pct = 100;
            endcase
            fetch_en       = ($urandom_range(99) < en_pct);
            inst_ready     = ($urandom_range(99) < rdy_pct);
            imem_req_ready = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = pick_target();
            imem_rsp_data  = $urandom;
            imem_rsp_err   = ($urandom_range(99) < 10);
            imem_rsp_valid = stray || ((txn == T_AWAIT) && ($urandom_range(99) < 60));

            // Advance the model across the coming edge.
            cnt0 = mq.size();
            if (cnt0 != 0 && inst_ready) begin
                void'(mq.pop_front());
                pops++;
            end
            nxt_valid = 1'b0;
            case (txn)
                T_NONE: begin
                    nxt_valid = fetch_en && !redirect_valid && (cnt0 < DEPTH);
                end
                T_PRES: begin
                    new_pres = 1'b0;
                    if (redirect_valid) taint = 1'b1;
                    if (imem_req_ready) begin
                        next_addr = held_addr + 32'd4;
                        txn       = T_AWAIT;
                    end else begin
                        nxt_valid = 1'b1;
                    end
                end
                default: begin
                    if (redirect_valid) taint = 1'b1;
                    if (imem_rsp_valid) begin
                        if (!taint) begin
                            check("slot_free", mq.size() < DEPTH, 1);
                            mq.push_back('{data: imem_rsp_data, pc: held_addr, fault: imem_rsp_err});
                        end
                        nxt_valid = !taint && fetch_en && (mq.size() < DEPTH);
                        txn       = T_NONE;
                    end
                end
            endcase
            if (nxt_valid && txn != T_PRES) begin
                txn       = T_PRES;
                taint     = 1'b0;
                new_pres  = 1'b1;
                held_addr = next_addr;
            end
            if (redirect_valid) begin
                next_addr = redirect_pc & ~32'd3;
                mq.delete();
            end
            exp_req_valid = nxt_valid;

            @(negedge clk);
        end

        check("progress", pops > 200, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
